processing_element_ws: RTL and testbench

Weight-stationary multiply-accumulate processing element for a systolic array. Each PE holds one stationary weight, passes activations horizontally (`a_in` → `a_out`) and partial sums vertically (`d_in` → `d_out`), and forwards its control code one cycle later to the next PE. In load mode the partial-sum path becomes a weight shift chain, so one column of PEs is preloaded from the top.

---
 rtl/processing_element_ws.sv | 91 +++++++++
 tb/tb_processing_element_ws.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/processing_element_ws.sv
`default_nettype none
// ============================================================================
// Module   : processing_element_ws
// Brief    : Weight-stationary multiply-accumulate PE for a systolic array.
//            Optional macro PE_SIGNED_EN selects two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
module processing_element_ws #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              control,
  input  logic [WORD_WIDTH-1:0]   a_in,
  input  logic [4*WORD_WIDTH-1:0] d_in,
  output logic [1:0]              control_out,
  output logic [WORD_WIDTH-1:0]   a_out,
  output logic [4*WORD_WIDTH-1:0] d_out
);

  localparam int ACC_WIDTH  = 4 * WORD_WIDTH;
  localparam int PROD_WIDTH = 2 * WORD_WIDTH;

  localparam logic [1:0] c_OP_LOAD    = 2'b01;
  localparam logic [1:0] c_OP_COMPUTE = 2'b10;

`ifdef PE_SIGNED_EN
  localparam logic c_SIGNED = 1'b1;
`else
  localparam logic c_SIGNED = 1'b0;
`endif

  logic [WORD_WIDTH-1:0] r_weight;
  logic [WORD_WIDTH-1:0] r_a_out;
  logic [ACC_WIDTH-1:0]  r_d_out;
  logic [1:0]            r_control_out;

  logic                  w_a_sign;
  logic                  w_w_sign;
  logic                  w_p_sign;
  logic [PROD_WIDTH-1:0] w_a_ext;
  logic [PROD_WIDTH-1:0] w_w_ext;
  logic [PROD_WIDTH-1:0] w_product;
  logic [ACC_WIDTH-1:0]  w_product_ext;
  logic [ACC_WIDTH-1:0]  w_weight_ext;
  logic [ACC_WIDTH-1:0]  w_mac;

  // Operands are extended to the product width first; the low 2N bits of
  // that product are the exact N x N result in either signedness.
  assign w_a_sign  = c_SIGNED & a_in[WORD_WIDTH-1];
  assign w_w_sign  = c_SIGNED & r_weight[WORD_WIDTH-1];
  assign w_a_ext   = {{WORD_WIDTH{w_a_sign}}, a_in};
  assign w_w_ext   = {{WORD_WIDTH{w_w_sign}}, r_weight};
  assign w_product = w_a_ext * w_w_ext;

  assign w_p_sign      = c_SIGNED & w_product[PROD_WIDTH-1];
  assign w_product_ext = {{(ACC_WIDTH-PROD_WIDTH){w_p_sign}}, w_product};
  assign w_weight_ext  = {{(ACC_WIDTH-WORD_WIDTH){w_w_sign}}, r_weight};
  assign w_mac         = d_in + w_product_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_weight      <= '0;
      r_a_out       <= '0;
      r_d_out       <= '0;
      r_control_out <= 2'b00;
    end else begin
      r_control_out <= control;
      case (control)
        c_OP_LOAD: begin
          // Previous weight moves down the column as the new one is captured.
          r_weight <= d_in[WORD_WIDTH-1:0];
          r_d_out  <= w_weight_ext;
        end
        c_OP_COMPUTE: begin
          r_d_out <= w_mac;
          r_a_out <= a_in;
        end
        default: begin
          // Idle and reserved codes hold all state.
        end
      endcase
    end
  end

  assign control_out = r_control_out;
  assign a_out       = r_a_out;
  assign d_out       = r_d_out;

endmodule
`default_nettype wire

// File: tb/tb_processing_element_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_processing_element_ws
// Brief    : Two chained PEs checked against a behavioural column model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_processing_element_ws;

  localparam int W  = 8;
  localparam int DW = 4 * W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    control;
  logic [W-1:0]  a_in1;
  logic [W-1:0]  a_in2;
  logic [DW-1:0] d_in;

  logic [1:0]    c1_out;
  logic [W-1:0]  a1_out;
  logic [DW-1:0] d1_out;
  logic [1:0]    c2_out;
  logic [W-1:0]  a2_out;
  logic [DW-1:0] d2_out;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the two-PE column.
  logic [1:0]    m_c [2];
  logic [W-1:0]  m_w [2];
  logic [W-1:0]  m_a [2];
  logic [DW-1:0] m_d [2];

  always #5 clk = ~clk;

  processing_element_ws #(.WORD_WIDTH(W)) u_pe1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .control     (control),
    .a_in        (a_in1),
    .d_in        (d_in),
    .control_out (c1_out),
    .a_out       (a1_out),
    .d_out       (d1_out)
  );

  processing_element_ws #(.WORD_WIDTH(W)) u_pe2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .control     (c1_out),
    .a_in        (a_in2),
    .d_in        (d1_out),
    .control_out (c2_out),
    .a_out       (a2_out),
    .d_out       (d2_out)
  );

  function automatic longint val(input logic [W-1:0] v);
`ifdef PE_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_c[k] = '0;
      m_w[k] = '0;
      m_a[k] = '0;
      m_d[k] = '0;
    end
  endtask

  task automatic model_pe(input int k, input logic [1:0] ctl,
                          input logic [W-1:0] a, input logic [DW-1:0] d);
    longint acc;
    m_c[k] = ctl;
    if (ctl == 2'b01) begin
      m_d[k] = DW'(val(m_w[k]));
      m_w[k] = d[W-1:0];
    end else if (ctl == 2'b10) begin
      acc    = longint'(d) + val(a) * val(m_w[k]);
      m_d[k] = DW'(acc);
      m_a[k] = a;
    end
  endtask

  task automatic model_step();
    logic [1:0]    c0;
    logic [DW-1:0] d0;
    c0 = m_c[0];
    d0 = m_d[0];
    model_pe(0, control, a_in1, d_in);
    model_pe(1, c0, a_in2, d0);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pe1_ctl",  DW'(c1_out), DW'(m_c[0]));
    check("pe1_aout", DW'(a1_out), DW'(m_a[0]));
    check("pe1_dout", d1_out,      m_d[0]);
    check("pe2_ctl",  DW'(c2_out), DW'(m_c[1]));
    check("pe2_aout", DW'(a2_out), DW'(m_a[1]));
    check("pe2_dout", d2_out,      m_d[1]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_c1"}, DW'(c1_out), '0);
    check({tag, "_a1"}, DW'(a1_out), '0);
    check({tag, "_d1"}, d1_out,      '0);
    check({tag, "_c2"}, DW'(c2_out), '0);
    check({tag, "_a2"}, DW'(a2_out), '0);
    check({tag, "_d2"}, d2_out,      '0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    reset_n = 1'b1;
    control = 2'($urandom_range(0, 3));
    a_in1   = W'($urandom);
    a_in2   = W'($urandom);
    d_in    = DW'($urandom);
    model_reset();
    #1 reset_n = 1'b0;
    #1 check_zero("reset_async");
    @(negedge clk);
    reset_n = 1'b1;
    control = 2'b00;
    a_in1   = '0;
    a_in2   = '0;
    d_in    = '0;
    cycle();
    cycle();
    check_zero("reset_idle");

    // Load 3, 4, 5 into the column.
    control = 2'b01;
    d_in = 3;  cycle(); check("load_d1_0", d1_out, 32'd0);
    d_in = 4;  cycle(); check("load_d1_1", d1_out, 32'd3);
    d_in = 5;  cycle(); check("load_d1_2", d1_out, 32'd4);

    // Compute: PE2 still finishes its load on the first compute cycle.
    control = 2'b10; d_in = 4; a_in1 = 2; a_in2 = 3;
    cycle(); check("chain_pe1", d1_out, 32'd14);
    cycle(); check("chain_pe2", d2_out, 32'd26);

    // Activation pass-through and idle/reserved hold.
    a_in1 = 7; d_in = 0;
    cycle(); check("apass", DW'(a1_out), 32'd7);
             check("apass_d", d1_out, 32'd35);
    control = 2'b00; a_in1 = 8'h5A; d_in = 32'h1234_5678;
    cycle(); check("idle_a", DW'(a1_out), 32'd7);
             check("idle_d", d1_out, 32'd35);
    control = 2'b11; a_in1 = 8'hC3; d_in = 32'h8765_4321;
    cycle(); check("rsv_a", DW'(a1_out), 32'd7);
             check("rsv_d", d1_out, 32'd35);
    control = 2'b10; a_in1 = 1; d_in = 0;
    cycle(); check("hold_weight", d1_out, 32'd5);

`ifdef PE_SIGNED_EN
    control = 2'b01; d_in = 32'h0000_00FE;
    cycle();
    control = 2'b10; a_in1 = 3; d_in = 10;
    cycle(); check("signed_mac", d1_out, 32'd4);
`else
    control = 2'b01; d_in = 32'hABCD_00FF;
    cycle();
    control = 2'b10; a_in1 = 8'hFF; d_in = 32'hFFFF_FFFF;
    cycle(); check("wrap", d1_out, 32'h0000_FE00);
`endif

    // Mid-operation reset with random inputs present.
    control = 2'($urandom_range(1, 2));
    a_in1   = W'($urandom);
    a_in2   = W'($urandom);
    d_in    = DW'($urandom);
    reset_n = 1'b0;
    model_reset();
    #1 check_zero("reset_mid");
    #4 reset_n = 1'b1;
    control = 2'b00;
    cycle();
    check_zero("reset_mid_idle");

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      control = 2'($urandom_range(0, 3));
      a_in1   = W'($urandom);
      a_in2   = W'($urandom);
      d_in    = DW'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
